// File: rtl/vmicro16_uart_rx_apb.sv
// vmicro16_uart_rx_apb: APB slave UART receiver, 8N1 serial frames into a byte FIFO
//
// Ports:
//   clk, reset            system clock, synchronous active-high reset
//   S_PADDR[0]            register select: 0 = DATA (pop head byte), 1 = STATUS
//   S_PWRITE, S_PSELx,    APB control; side effects only on the access-phase edge
//   S_PENABLE, S_PWDATA
//   S_PRDATA, S_PREADY    combinational read data / zero-wait ready, high-Z when unselected
//   rx_wire               asynchronous serial input, idle high
//   rx_irq                high while the FIFO holds at least one byte
// STATUS: [0] NE, [1] FULL, [2] OVR, [3] FERR, [4] PERR, [15:8] count; W1C on [4:2].
// Optional: define UART_RX_PARITY_EN for 8E1 frames with a PERR flag.
module vmicro16_uart_rx_apb #(
  parameter int BUS_WIDTH    = 16,
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [BUS_WIDTH-1:0] S_PADDR,
  input  logic                 S_PWRITE,
  input  logic                 S_PSELx,
  input  logic                 S_PENABLE,
  input  logic [BUS_WIDTH-1:0] S_PWDATA,
  output logic [BUS_WIDTH-1:0] S_PRDATA,
  output logic                 S_PREADY,
  input  logic                 rx_wire,
  output logic                 rx_irq
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int NW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  localparam state_t POST_DATA = PARITY;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  localparam state_t POST_DATA = STOP;
`endif
  state_t state_q, state_d;
  logic rx_m_q, rx_s_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] sh_q, sh_d;
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [NW-1:0] count_q, count_d;
  logic ovr_q, ovr_d, ferr_q, ferr_d;
  logic [7:0] mem_q [FIFO_DEPTH];
  logic tick, access, w1c, pop, push, full, ne, stop_now, good, par_bad, perr, unused;
  logic [15:0] status, rdata;
  assign tick = cnt_q == LAST;
  assign access = S_PSELx & S_PENABLE;
  assign w1c = access & S_PWRITE & S_PADDR[0];
  assign ne = count_q != '0;
  assign full = count_q == NW'(FIFO_DEPTH);
  assign pop = access & ~S_PWRITE & ~S_PADDR[0] & ne;
  assign stop_now = (state_q == STOP) & tick;
  assign good = stop_now & rx_s_q & ~par_bad;
  // a pop on the same edge frees the slot, so a full FIFO still accepts the byte
  assign push = good & (~full | pop);
  assign unused = ^{S_PADDR[BUS_WIDTH-1:1], S_PWDATA};
`ifdef UART_RX_PARITY_EN
  logic par_q, par_d, perr_q, perr_d;
  assign par_bad = par_q != ^sh_q;
  assign perr = perr_q;
  assign par_d = (state_q == PARITY && tick) ? rx_s_q : par_q;
  assign perr_d = (perr_q & ~(w1c & S_PWDATA[4])) | (stop_now & par_bad);
  always_ff @(posedge clk) begin
    par_q <= reset ? 1'b0 : par_d;
    perr_q <= reset ? 1'b0 : perr_d;
  end
`else
  assign par_bad = 1'b0;
  assign perr = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    cnt_d = tick ? '0 : cnt_q + 1'b1;
    bit_d = bit_q;
    sh_d = sh_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rx_s_q) state_d = START;
      end
      // mid start bit: still low means a real frame, high means a glitch
      START: if (cnt_q == HALF) begin
        cnt_d = '0;
        bit_d = '0;
        state_d = rx_s_q ? IDLE : DATA;
      end
      DATA: if (tick) begin
        sh_d = {rx_s_q, sh_q[7:1]};
        bit_d = bit_q + 3'd1;
        if (&bit_q) state_d = POST_DATA;
      end
`ifdef UART_RX_PARITY_EN
      PARITY: if (tick) state_d = STOP;
`endif
      STOP: if (tick) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // set beats clear when a W1C lands on the same edge as a new error
  always_comb begin
    wr_d = wr_q + PW'(push);
    rd_d = rd_q + PW'(pop);
    count_d = count_q + NW'(push) - NW'(pop);
    ovr_d = (ovr_q & ~(w1c & S_PWDATA[2])) | (good & full & ~pop);
    ferr_d = (ferr_q & ~(w1c & S_PWDATA[3])) | (stop_now & ~rx_s_q);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_m_q <= 1'b1;
      rx_s_q <= 1'b1;
      state_q <= IDLE;
      cnt_q <= '0;
      bit_q <= '0;
      sh_q <= '0;
      wr_q <= '0;
      rd_q <= '0;
      count_q <= '0;
      ovr_q <= 1'b0;
      ferr_q <= 1'b0;
    end else begin
      rx_m_q <= rx_wire;
      rx_s_q <= rx_m_q;
      state_q <= state_d;
      cnt_q <= cnt_d;
      bit_q <= bit_d;
      sh_q <= sh_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      count_q <= count_d;
      ovr_q <= ovr_d;
      ferr_q <= ferr_d;
    end
  end
  always_ff @(posedge clk) if (push) mem_q[wr_q] <= sh_q;
  assign status = {8'(count_q), 3'b000, perr, ferr_q, ovr_q, full, ne};
  assign rdata = S_PADDR[0] ? status : {8'h00, ne ? mem_q[rd_q] : 8'h00};
  assign S_PRDATA = S_PSELx ? BUS_WIDTH'(rdata) : 'z;
  assign S_PREADY = S_PSELx ? 1'b1 : 1'bz;
  assign rx_irq = ne;
endmodule

// File: doc/vmicro16_uart_rx_apb.md
Name: vmicro16_uart_rx_apb

Overview:
- APB slave UART receiver. It deserialises 8N1 frames from an external pin into a byte FIFO that cores read over the shared APB peripheral bus.
- Sits beside the UART transmitter on the shared bus. It is selected by one PSELx line from the APB interconnect.
- Completes the serial link: the SoC can receive commands and data, not only transmit.

Parameters:
- BUS_WIDTH, 16, APB data/address width.
- CLKS_PER_BIT, 434, clk cycles per serial bit (50 MHz / 115200). Must be ≥ 4.
- FIFO_DEPTH, 8, RX FIFO entries. Power of two, 2..128.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- S_PADDR  in  BUS_WIDTH  APB address; only S_PADDR[0] is decoded (0=DATA, 1=STATUS).
- S_PWRITE  in  1  APB write strobe.
- S_PSELx  in  1  slave select from the interconnect.
- S_PENABLE  in  1  APB access phase.
- S_PWDATA  in  BUS_WIDTH  APB write data.
- S_PRDATA  out  BUS_WIDTH  read data; high-Z when S_PSELx=0.
- S_PREADY  out  1  transfer ready; high-Z when S_PSELx=0.
- rx_wire  in  1  asynchronous serial input, idle high.
- rx_irq  out  1  high while the FIFO is non-empty.

Behaviour:
- Reset:
  - FSM goes to IDLE; bit and clock counters are 0.
  - FIFO is empty (pointers 0, count 0); all sticky flags are 0.
  - rx_irq=0.
  - Synchroniser flops are set to 1.
  - Applies mid-frame: any partial byte is discarded.
- Input path: rx_wire passes through a 2-FF synchroniser (rx_s). All decisions use rx_s. Synchroniser latency is 2 cycles.
- Bit counter and sampling:
  - The clock counter counts 0..CLKS_PER_BIT-1.
  - A "sample" occurs when the counter reaches its terminal value; the counter then reloads to 0.
- FSM:
  - IDLE: when rx_s=0, go to START and clear the counter.
  - START: at count CLKS_PER_BIT/2-1, sample rx_s. If 0, go to DATA and clear the counter and bit index. If 1 (glitch), go back to IDLE.
  - DATA: every CLKS_PER_BIT cycles, shift rx_s into the shift register, LSB first. After the 8th sample, go to STOP.
  - STOP: after CLKS_PER_BIT cycles, sample rx_s.
    - rx_s=1 and FIFO not full: push the byte.
    - rx_s=1 and FIFO full: drop the byte; set OVR.
    - rx_s=0: drop the byte; set FERR.
    - In every case go to IDLE. A new start bit is accepted the next cycle.
- FIFO: circular buffer with log2(FIFO_DEPTH)-bit pointers that wrap modulo FIFO_DEPTH. Count range is 0..FIFO_DEPTH.
- APB protocol:
  - Zero wait states: S_PREADY=1 whenever S_PSELx=1.
  - Side effects happen only on the clock edge where S_PSELx & S_PENABLE = 1.
  - S_PRDATA is combinational and valid in both the setup and access phases.
- DATA read: S_PRDATA = {8'h00, head byte}. The access-phase edge pops the FIFO if it is non-empty. When empty, the read returns 16'h0000 and nothing is popped.
- STATUS read bit fields:
  - [0] NE (not empty)
  - [1] FULL
  - [2] OVR
  - [3] FERR
  - [4] PERR
  - [7:5] 0
  - [15:8] count
- STATUS write: W1C on bits [4:2]; other bits are ignored.
- DATA write: no effect.
- Simultaneous push and pop in the same cycle:
  - Both occur and count is unchanged.
  - Pop while full plus push: the push succeeds and OVR is not set.
  - Pop while empty plus push: the pop does nothing; the pushed byte becomes visible the next cycle.
- Simultaneous W1C and a new flag event on the same bit: set wins.
- rx_irq = NE, combinational from count.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined: the frame is 8E1.
  - A PARITY state follows DATA and samples one bit after CLKS_PER_BIT cycles.
  - In STOP, if the received parity ≠ XOR of the data bits, drop the byte and set PERR.
  - FERR takes precedence; both flags are set if both errors occur.
- Undefined: the PARITY state is absent, and PERR reads 0 and ignores W1C.

Test Plan (CLKS_PER_BIT=16, FIFO_DEPTH=4):
- Reset, then read STATUS -> 16'h0000; rx_irq=0; DATA read -> 16'h0000 with count still 0.
- Drive frame 0xA5 (8N1) -> within 16 cycles of the stop-bit midpoint STATUS=16'h0101 and rx_irq=1. DATA read -> 16'h00A5, after which STATUS=16'h0000.
- Five frames 0x01..0x05 with no reads -> STATUS=16'h0407 (FULL, NE, OVR). Four DATA reads -> 0x01..0x04 in order. W1C 16'h0004 to STATUS -> OVR=0.
- Frame 0x3C with stop bit 0 -> STATUS bit 3 set, count 0. A 6-cycle low glitch on idle line -> no state change.
- Pop of a full FIFO on the same edge as a push -> count stays 4, OVR stays 0, and a 5th read returns the new byte. Reset asserted mid-DATA -> FIFO empty, next clean frame 0x7E received correctly.
- With UART_RX_PARITY_EN: byte 0x03 with parity 1 -> PERR set, nothing pushed. With parity 0 -> pushed, DATA reads 16'h0003.
